uart_apb_if: RTL

UART_APB_IF -- requirements
Module: uart_apb_if

---
 rtl/uart_pkg.sv | 26 ++
 rtl/uart_apb_if.sv | 136 +++++++++++++
 2 files changed

// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
//   Definitions shared by the UART register block and its APB front end:
//   byte offsets of the four CPU-visible registers, the register count and
//   the state encoding of the APB access FSM.
// ---------------------------------------------------------------------------
package uart_pkg;

  // Register byte offsets within the UART window.
  localparam logic [3:0] REG_STAT_OFF = 4'h0;
  localparam logic [3:0] REG_CTRL_OFF = 4'h4;
  localparam logic [3:0] REG_TX_OFF   = 4'h8;
  localparam logic [3:0] REG_RX_OFF   = 4'hC;

  localparam int REG_COUNT = 4;

  // APB access FSM states.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_READ  = 3'd2,
    ST_CAPT  = 3'd3,
    ST_RESP  = 3'd4
  } apb_state_e;

endpackage : uart_pkg

// File: rtl/uart_apb_if.sv
// ---------------------------------------------------------------------------
// uart_apb_if
//   APB slave that converts each APB transfer into a single one-cycle
//   register strobe toward the UART register controller.
//   Write: setup T0 -> wr_en_cpu_o at T1 -> pready_o at T2.
//   Read : setup T0 -> rd_en_cpu_o at T1 -> capture cpu_data_i at T2
//          -> pready_o at T3 with prdata_o valid.
//
// Ports
//   clk_i, rst_i           clock, synchronous active-high reset
//   psel_i, penable_i,
//   pwrite_i, paddr_i,
//   pwdata_i               APB request
//   pready_o, prdata_o,
//   pslverr_o              APB response
//   wr_en_cpu_o,
//   rd_en_cpu_o            one-cycle register strobes (never both high)
//   cpu_addr_o, cpu_data_o register index (paddr_i[3:2]) and write data
//   cpu_data_i             register read data, valid the cycle after rd_en
//
// Build option
//   UART_APB_PSLVERR_EN    when defined, a misaligned address or one outside
//                          the 16-byte window is answered at once with
//                          pslverr_o; otherwise pslverr_o is 0 and addresses
//                          alias onto paddr_i[3:2].
// ---------------------------------------------------------------------------
module uart_apb_if
  import uart_pkg::*;
#(
  parameter int APB_ADDR_W     = 12,
  parameter int CPU_ADDR_WIDTH = 2,
  parameter int CPU_DATA_WIDTH = 32
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      psel_i,
  input  logic                      penable_i,
  input  logic                      pwrite_i,
  input  logic [APB_ADDR_W-1:0]     paddr_i,
  input  logic [CPU_DATA_WIDTH-1:0] pwdata_i,
  output logic                      pready_o,
  output logic [CPU_DATA_WIDTH-1:0] prdata_o,
  output logic                      pslverr_o,
  output logic                      wr_en_cpu_o,
  output logic                      rd_en_cpu_o,
  output logic [CPU_ADDR_WIDTH-1:0] cpu_addr_o,
  output logic [CPU_DATA_WIDTH-1:0] cpu_data_o,
  input  logic [CPU_DATA_WIDTH-1:0] cpu_data_i
);

  apb_state_e                state_reg, state_next;
  logic [CPU_ADDR_WIDTH-1:0] cpu_addr_reg;
  logic [CPU_DATA_WIDTH-1:0] cpu_data_reg;
  logic [CPU_DATA_WIDTH-1:0] prdata_reg;
  logic                      setup_phase;
  logic                      accept;
  logic                      decode_err;

  assign setup_phase = psel_i && !penable_i;

`ifdef UART_APB_PSLVERR_EN
  logic err_reg;

  assign decode_err = (paddr_i[1:0] != 2'b00) ||
                      (paddr_i[APB_ADDR_W-1:4] != '0);
`else
  // Out-of-window and byte-lane bits are deliberately ignored here.
  logic unused_addr_bits;

  assign unused_addr_bits = ^{paddr_i[APB_ADDR_W-1:4], paddr_i[1:0]};
  assign decode_err       = 1'b0;
`endif

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (setup_phase) begin
          accept = 1'b1;
          if (decode_err)    state_next = ST_RESP;
          else if (pwrite_i) state_next = ST_WRITE;
          else               state_next = ST_READ;
        end
      end
      ST_WRITE: state_next = ST_RESP;
      ST_READ:  state_next = ST_CAPT;
      ST_CAPT:  state_next = ST_RESP;
      ST_RESP:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg    <= ST_IDLE;
      cpu_addr_reg <= '0;
      cpu_data_reg <= '0;
      prdata_reg   <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        cpu_addr_reg <= CPU_ADDR_WIDTH'(paddr_i[3:2]);
        cpu_data_reg <= pwdata_i;
        // Reads keep the previous value until CAPT overwrites it.
        if (pwrite_i || decode_err) prdata_reg <= '0;
      end
      if (state_reg == ST_CAPT) prdata_reg <= cpu_data_i;
    end
  end

`ifdef UART_APB_PSLVERR_EN
  always_ff @(posedge clk_i) begin
    if (rst_i)       err_reg <= 1'b0;
    else if (accept) err_reg <= decode_err;
  end
`endif

  // Strobes and pready are decoded from the state; gating with rst_i keeps
  // them low even in the first reset cycle while the state is still stale.
  assign wr_en_cpu_o = (state_reg == ST_WRITE) && !rst_i;
  assign rd_en_cpu_o = (state_reg == ST_READ)  && !rst_i;
  assign pready_o    = (state_reg == ST_RESP) && psel_i && penable_i && !rst_i;

`ifdef UART_APB_PSLVERR_EN
  assign pslverr_o = pready_o && err_reg;
`else
  assign pslverr_o = 1'b0;
`endif

  assign prdata_o   = prdata_reg;
  assign cpu_addr_o = cpu_addr_reg;
  assign cpu_data_o = cpu_data_reg;

endmodule : uart_apb_if
